// File: rtl/cordic_pipe_param.sv
// Fully pipelined CORDIC (rotation/vectoring per sample), latency STAGES+1 (STAGES+2 with gain comp), no backpressure.
// Define CORDIC_GAIN_COMP_EN to add a 1/K scaling register stage on x and y (z delayed to match).
module cordic_pipe_param #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  // atan(2^-i) in Q16 radians, truncated
  function automatic logic signed [WIDTH-1:0] atan_c(input int i);
    case (i)
      0:       atan_c = WIDTH'(51471);
      1:       atan_c = WIDTH'(30385);
      2:       atan_c = WIDTH'(16054);
      3:       atan_c = WIDTH'(8149);
      4:       atan_c = WIDTH'(4090);
      5:       atan_c = WIDTH'(2047);
      6:       atan_c = WIDTH'(1023);
      7:       atan_c = WIDTH'(511);
      8:       atan_c = WIDTH'(255);
      9:       atan_c = WIDTH'(127);
      10:      atan_c = WIDTH'(63);
      11:      atan_c = WIDTH'(31);
      12:      atan_c = WIDTH'(15);
      13:      atan_c = WIDTH'(7);
      14:      atan_c = WIDTH'(3);
      15:      atan_c = WIDTH'(1);
      default: atan_c = '0;
    endcase
  endfunction

  // Index 0 is the input register; index i+1 holds the result of micro-rotation i.
  logic signed [WIDTH-1:0] x_q [0:STAGES];
  logic signed [WIDTH-1:0] y_q [0:STAGES];
  logic signed [WIDTH-1:0] z_q [0:STAGES];
  logic signed [WIDTH-1:0] x_d [0:STAGES];
  logic signed [WIDTH-1:0] y_d [0:STAGES];
  logic signed [WIDTH-1:0] z_d [0:STAGES];
  logic [STAGES:0]         vld_q, vld_d;
  logic [STAGES-1:0]       mode_q, mode_d;

  logic                    dir;
  logic signed [WIDTH-1:0] xs, ys, at;

  always_comb begin
    dir       = 1'b0;
    xs        = '0;
    ys        = '0;
    at        = '0;
    x_d[0]    = x_in;
    y_d[0]    = y_in;
    z_d[0]    = z_in;
    vld_d     = '0;
    mode_d    = '0;
    vld_d[0]  = in_valid;
    mode_d[0] = in_mode;
    for (int i = 0; i < STAGES; i++) begin
      // dir=1 means d=+1 (counter-clockwise micro-rotation)
      dir = mode_q[i] ? y_q[i][WIDTH-1] : ~z_q[i][WIDTH-1];
      xs  = x_q[i] >>> i;
      ys  = y_q[i] >>> i;
      at  = atan_c(i);
      x_d[i+1]   = dir ? (x_q[i] - ys) : (x_q[i] + ys);
      y_d[i+1]   = dir ? (y_q[i] + xs) : (y_q[i] - xs);
      z_d[i+1]   = dir ? (z_q[i] - at) : (z_q[i] + at);
      vld_d[i+1] = vld_q[i];
    end
    for (int i = 1; i < STAGES; i++) begin
      mode_d[i] = mode_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= STAGES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      vld_q  <= '0;
      mode_q <= '0;
    end else begin
      for (int i = 0; i <= STAGES; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
        z_q[i] <= z_d[i];
      end
      vld_q  <= vld_d;
      mode_q <= mode_d;
    end
  end

  logic signed [WIDTH-1:0] last_x, last_y, last_z;
  logic                    last_vld;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [17:0] INV_GAIN = 18'sd39797;

  logic signed [WIDTH+17:0] prod_x, prod_y;
  logic signed [WIDTH-1:0]  gx_q, gy_q, gz_q, gx_d, gy_d, gz_d;
  logic                     gv_q, gv_d;

  always_comb begin
    prod_x = x_q[STAGES] * INV_GAIN;
    prod_y = y_q[STAGES] * INV_GAIN;
    gx_d   = WIDTH'(prod_x >>> 16);
    gy_d   = WIDTH'(prod_y >>> 16);
    gz_d   = z_q[STAGES];
    gv_d   = vld_q[STAGES];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_q <= '0;
      gy_q <= '0;
      gz_q <= '0;
      gv_q <= 1'b0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
      gz_q <= gz_d;
      gv_q <= gv_d;
    end
  end

  always_comb begin
    last_x   = gx_q;
    last_y   = gy_q;
    last_z   = gz_q;
    last_vld = gv_q;
  end
`else
  always_comb begin
    last_x   = x_q[STAGES];
    last_y   = y_q[STAGES];
    last_z   = z_q[STAGES];
    last_vld = vld_q[STAGES];
  end
`endif

  // Output registers hold the last valid result across bubbles.
  logic signed [WIDTH-1:0] x_out_q, y_out_q, z_out_q, x_out_d, y_out_d, z_out_d;
  logic                    out_valid_q, out_valid_d;

  always_comb begin
    x_out_d     = last_vld ? last_x : x_out_q;
    y_out_d     = last_vld ? last_y : y_out_q;
    z_out_d     = last_vld ? last_z : z_out_q;
    out_valid_d = last_vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      z_out_q     <= z_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cordic_pipe_param.sv
// Bench for cordic_pipe_param: vector table, streaming scoreboard, mid-stream reset, small-parameter instance.
module tb_cordic_pipe_param;
  localparam int W  = 32;
  localparam int S  = 16;
  localparam int W2 = 24;
  localparam int S2 = 8;
`ifdef CORDIC_GAIN_COMP_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif
  localparam int LAT  = S + 1 + int'(GC);
  localparam int LAT2 = S2 + 1 + int'(GC);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0, in_mode = 1'b0;
  logic signed [W-1:0]  x_in = '0, y_in = '0, z_in = '0;
  logic                 out_valid;
  logic signed [W-1:0]  x_out, y_out, z_out;

  logic                 b_in_valid = 1'b0, b_in_mode = 1'b0;
  logic signed [W2-1:0] b_x_in = '0, b_y_in = '0, b_z_in = '0;
  logic                 b_out_valid;
  logic signed [W2-1:0] b_x_out, b_y_out, b_z_out;

  cordic_pipe_param #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  cordic_pipe_param #(.WIDTH(W2), .STAGES(S2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_mode(b_in_mode),
    .x_in(b_x_in), .y_in(b_y_in), .z_in(b_z_in),
    .out_valid(b_out_valid), .x_out(b_x_out), .y_out(b_y_out), .z_out(b_z_out)
  );

  typedef struct {
    string name;
    bit    m;
    int    x, y, z;
    int    ex, ey, ez;
    int    tx, ty, tz;
  } vec_t;

  typedef struct {
    string name;
    int    ex, ey, ez;
    int    tx, ty, tz;
    int    cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   hold_en = 1'b0;
  int   atan_tab [16] = '{51471, 30385, 16054, 8149, 4090, 2047, 1023, 511,
                          255, 127, 63, 31, 15, 7, 3, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint want, input longint tol);
    longint d;
    checks++;
    d = act - want;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, want, tol);
    end
  endtask

  function automatic int gc(input int v);
    if (GC) return int'((longint'(v) * 39797) >>> 16);
    return v;
  endfunction

  // Bit-accurate reference of the micro-rotation sequence.
  function automatic exp_t model(input bit m, input int x0, input int y0, input int z0);
    exp_t e;
    int   x, y, z, nx, ny;
    bit   d;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < S; i++) begin
      d  = m ? (y < 0) : (z >= 0);
      nx = d ? x - (y >>> i) : x + (y >>> i);
      ny = d ? y + (x >>> i) : y - (x >>> i);
      z  = d ? z - atan_tab[i] : z + atan_tab[i];
      x  = nx;
      y  = ny;
    end
    e.name = "";
    e.ex = gc(x); e.ey = gc(y); e.ez = z;
    e.tx = 0; e.ty = 0; e.tz = 0; e.cyc = 0;
    return e;
  endfunction

  task automatic zero_last();
    last.name = "reset";
    last.ex = 0; last.ey = 0; last.ez = 0;
    last.tx = 0; last.ty = 0; last.tz = 0; last.cyc = 0;
  endtask

  task automatic drive(input bit m, input int x, input int y, input int z, input exp_t e);
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = m; x_in = x; y_in = y; z_in = z;
    e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_mode  = 1'($urandom_range(0, 1));
      x_in = $urandom; y_in = $urandom; z_in = $urandom;
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    exp_t e;
    zero_last();
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious out_valid at cycle %0d: got x_out %0d, want no output", cyc, x_out);
        end else begin
          e = sb.pop_front();
          chk({e.name, " latency"}, cyc, e.cyc, 0);
          chk({e.name, " x"}, x_out, e.ex, e.tx);
          chk({e.name, " y"}, y_out, e.ey, e.ty);
          chk({e.name, " z"}, z_out, e.ez, e.tz);
          last = e;
        end
      end else if (hold_en) begin
        chk("hold x", x_out, last.ex, last.tx);
        chk("hold y", y_out, last.ey, last.ty);
        chk("hold z", z_out, last.ez, last.tz);
      end
    end
  end

  initial begin
    vec_t tv [7];
    exp_t e;
    int   c, n, seen, bx, by;
    bit   m;

    tv[0] = '{"rot90",  1'b0, 39797, 0,      102944,  0,      65536,  0,      32, 32, 4};
    tv[1] = '{"vec45",  1'b1, 65536, 65536,  0,       152630, 0,      51472,  64, 32, 4};
    tv[2] = '{"gain",   1'b0, 65536, 0,      0,       107922, 0,      0,      32, 32, 4};
    tv[3] = '{"rotm90", 1'b0, 39797, 0,      -102944, 0,      -65536, 0,      32, 32, 4};
    tv[4] = '{"vecm45", 1'b1, 65536, -65536, 0,       152630, 0,      -51472, 64, 32, 4};
    tv[5] = '{"rot0y",  1'b0, 0,     39797,  0,       0,      65536,  0,      32, 32, 4};
    tv[6] = '{"rot60",  1'b0, 39797, 0,      68629,   32768,  56756,  0,      32, 32, 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", out_valid, 0, 0);
    chk("reset x_out", x_out, 0, 0);
    chk("reset y_out", y_out, 0, 0);
    chk("reset z_out", z_out, 0, 0);
    chk("reset small out_valid", b_out_valid, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_en = 1'b1;
    idle(2);

    foreach (tv[k]) begin
      e.name = tv[k].name;
      e.ex = gc(tv[k].ex); e.ey = gc(tv[k].ey); e.ez = tv[k].ez;
      e.tx = tv[k].tx; e.ty = tv[k].ty; e.tz = tv[k].tz;
      drive(tv[k].m, tv[k].x, tv[k].y, tv[k].z, e);
      idle(3);
    end
    idle(LAT + 4);
    chk("table drain", sb.size(), 0, 0);

    for (int k = 0; k < 20; k++) begin
      m = k[0];
      if (!m) begin
        e = model(1'b0, 39797, 0, -110000 + k * 11000);
        e.name = $sformatf("stream%0d", k);
        drive(1'b0, 39797, 0, -110000 + k * 11000, e);
      end else begin
        e = model(1'b1, 60000 - k * 1000, -50000 + k * 5000, k * 100);
        e.name = $sformatf("stream%0d", k);
        drive(1'b1, 60000 - k * 1000, -50000 + k * 5000, k * 100, e);
      end
    end
    idle(LAT + 4);
    chk("stream drain", sb.size(), 0, 0);

    for (int k = 0; k < 8; k++) begin
      e = model(1'b0, 30000, 10000, k * 7000);
      e.name = $sformatf("flushed%0d", k);
      drive(1'b0, 30000, 10000, k * 7000, e);
    end
    #2;
    zero_last();
    sb.delete();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async reset out_valid", out_valid, 0, 0);
    chk("async reset x_out", x_out, 0, 0);
    chk("async reset y_out", y_out, 0, 0);
    chk("async reset z_out", z_out, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(LAT + 10);

    e.name = "post-reset rot90";
    e.ex = gc(tv[0].ex); e.ey = gc(tv[0].ey); e.ez = tv[0].ez;
    e.tx = tv[0].tx; e.ty = tv[0].ty; e.tz = tv[0].tz;
    drive(tv[0].m, tv[0].x, tv[0].y, tv[0].z, e);
    idle(LAT + 4);
    chk("post-reset drain", sb.size(), 0, 0);

    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_mode = 1'b0;
    b_x_in = 24'sd39797; b_y_in = '0; b_z_in = 24'sd51472;
    c = cyc + 1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    n = 0; seen = 0; bx = 0; by = 0;
    repeat (LAT2 + 6) begin
      @(negedge clk);
      if (b_out_valid) begin
        n++;
        seen = cyc;
        bx = b_x_out;
        by = b_y_out;
      end
    end
    chk("small pulses", n, 1, 0);
    chk("small latency", seen, c + LAT2, 0);
    chk("small x", bx, gc(46341), 512);
    chk("small y", by, gc(46341), 512);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
